card_atr_sequencer: RTL and testbench

Card-side controller for the half-duplex UART interface of the ISO7816-3 card model. After reset release it waits a fixed number of clocks, then streams a programmable Answer-To-Reset (ATR) byte list into the UART using its write strobe and status handshakes. It then switches to receive service, draining each received byte from the UART and presenting it upstream. The block replaces ad-hoc testbench sequencing of the UART and sits between the card-model logic and the UART instance.

---
 rtl/iso_seq_pkg.sv | 33 +++
 rtl/card_atr_sequencer_if.sv | 43 ++++
 rtl/iso_seq_timer.sv | 40 ++++
 rtl/card_atr_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_card_atr_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iso_seq_pkg.sv
// -----------------------------------------------------------------------------
// iso_seq_pkg
// Shared definitions for the ISO7816-3 card-side ATR sequencer:
//   - state_t             : sequencer FSM states
//   - TX_RUN..BUFFER_FULL : bit positions inside the UART status byte
//   - DEFAULT_ATR_DELAY   : clocks from reset release to the first ATR write
// -----------------------------------------------------------------------------
package iso_seq_pkg;

   localparam int DEFAULT_ATR_DELAY = 400;

   // UART status byte layout, MSB first
   localparam int TX_RUN        = 7;
   localparam int TX_PENDING    = 6;
   localparam int RX_RUN        = 5;
   localparam int RX_START_BIT  = 4;
   localparam int IS_TX         = 3;
   localparam int OVERRUN_ERROR = 2;
   localparam int FRAME_ERROR   = 1;
   localparam int BUFFER_FULL   = 0;

   typedef enum logic [2:0] {
      ST_DELAY    = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_WAIT_TX  = 3'd3,
      ST_FLUSH    = 3'd4,
      ST_RX_IDLE  = 3'd5,
      ST_READ     = 3'd6,
      ST_RX_CLEAR = 3'd7
   } state_t;

endpackage

// File: rtl/card_atr_sequencer_if.sv
// -----------------------------------------------------------------------------
// card_atr_sequencer_if
// Bundles every non-clock signal of the ATR sequencer.
//   ATR source : atrLen (5b), atrIndex (log2 ATR_MAX), atrByte (8b)
//   UART side  : uartDataIn, uartNWeDataIn, uartNCsDataOut, uartNCsStatusOut,
//                uartStatus, uartDataOut
//   Upstream   : rxData, rxValid, rxError, atrDone, busy
// modport master : the sequencer
// modport slave  : the card model / UART side
// -----------------------------------------------------------------------------
interface card_atr_sequencer_if #(
   parameter int ATR_MAX = 16
);
   localparam int IW = $clog2(ATR_MAX);

   logic [4:0]    atrLen;
   logic [IW-1:0] atrIndex;
   logic [7:0]    atrByte;
   logic [7:0]    uartDataIn;
   logic          uartNWeDataIn;
   logic          uartNCsDataOut;
   logic          uartNCsStatusOut;
   logic [7:0]    uartStatus;
   logic [7:0]    uartDataOut;
   logic [7:0]    rxData;
   logic          rxValid;
   logic          rxError;
   logic          atrDone;
   logic          busy;

   modport master (
      input  atrLen, atrByte, uartStatus, uartDataOut,
      output atrIndex, uartDataIn, uartNWeDataIn, uartNCsDataOut,
             uartNCsStatusOut, rxData, rxValid, rxError, atrDone, busy
   );

   modport slave (
      output atrLen, atrByte, uartStatus, uartDataOut,
      input  atrIndex, uartDataIn, uartNWeDataIn, uartNCsDataOut,
             uartNCsStatusOut, rxData, rxValid, rxError, atrDone, busy
   );

endinterface

// File: rtl/iso_seq_timer.sv
// -----------------------------------------------------------------------------
// iso_seq_timer
// One-shot loadable down-counter. The first cycle i_start is seen, i_value is
// loaded; the count then runs down to zero and o_done stays high until reset.
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   i_start in  arm request (only the first one after reset loads)
//   i_value in  WIDTH  load value
//   o_done  out armed and count reached zero
// -----------------------------------------------------------------------------
module iso_seq_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;
   logic             r_armed;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_armed <= 1'b0;
      end else if (i_start && !r_armed) begin
         r_count <= i_value;
         r_armed <= 1'b1;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_done = r_armed && (r_count == '0);

endmodule

// File: rtl/card_atr_sequencer.sv
// -----------------------------------------------------------------------------
// card_atr_sequencer
// Card-side controller for the half-duplex ISO7816-3 UART. After reset it
// waits ATR_DELAY clocks, streams atrLen (clamped to ATR_MAX) ATR bytes into
// the UART, waits for the line to go idle, then services received bytes.
//   clk   in  card clock (also clocks the UART)
//   reset in  asynchronous active-high reset
//   bus   master modport of card_atr_sequencer_if (ATR source, UART
//         strobes/status, rxData/rxValid/rxError, atrDone, busy)
// All outputs are registered.
// -----------------------------------------------------------------------------
module card_atr_sequencer
   import iso_seq_pkg::*;
#(
   parameter int ATR_DELAY = DEFAULT_ATR_DELAY,
   parameter int ATR_MAX   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   card_atr_sequencer_if.master   bus
);

   localparam int          IW         = $clog2(ATR_MAX);
   localparam logic [4:0]  LEN_MAX    = 5'(ATR_MAX);
   // Timer arms on the first DELAY cycle, so it is loaded one short to put the
   // first write strobe in clock ATR_DELAY+1.
   localparam logic [15:0] DELAY_LOAD = 16'((ATR_DELAY > 0) ? ATR_DELAY - 1 : 0);

   state_t        r_state;
   logic [4:0]    r_len;
   logic [IW-1:0] r_index;
   logic          r_last;
   logic [7:0]    r_data_in;
   logic          r_nwe;
   logic          r_ncs_data;
   logic          r_ncs_status;
   logic [7:0]    r_rx_data;
   logic          r_rx_valid;
   logic          r_rx_error;
   logic          r_atr_done;
   logic          r_busy;

   logic          w_delay_done;
   logic [4:0]    w_len_clamped;
   logic          w_rx_phase;
   logic          w_line_error;
   logic          w_tx_idle;

   iso_seq_timer #(.WIDTH(16)) u_delay (
      .clk     (clk),
      .reset   (reset),
      .i_start (r_state == ST_DELAY),
      .i_value (DELAY_LOAD),
      .o_done  (w_delay_done)
   );

   assign w_len_clamped = (bus.atrLen > LEN_MAX) ? LEN_MAX : bus.atrLen;
   assign w_rx_phase    = r_state inside {ST_RX_IDLE, ST_READ, ST_RX_CLEAR};
   assign w_line_error  = bus.uartStatus[OVERRUN_ERROR] | bus.uartStatus[FRAME_ERROR];
   assign w_tx_idle     = !bus.uartStatus[TX_RUN] && !bus.uartStatus[IS_TX];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_DELAY;
         r_len        <= '0;
         r_index      <= '0;
         r_last       <= 1'b0;
         r_data_in    <= '0;
         r_nwe        <= 1'b1;
         r_ncs_data   <= 1'b1;
         r_ncs_status <= 1'b1;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_error   <= 1'b0;
         r_atr_done   <= 1'b0;
         r_busy       <= 1'b1;
      end else begin
         // NOTE: defaults first, so strobes and rxValid are single-cycle
         // pulses and only the states that assert them override.
         r_ncs_status <= 1'b0;
         r_nwe        <= 1'b1;
         r_ncs_data   <= 1'b1;
         r_rx_valid   <= 1'b0;

         if (w_rx_phase && w_line_error) begin
            r_rx_error <= 1'b1;
         end

         case (r_state)
            ST_DELAY: begin
               if (w_delay_done) begin
                  r_len <= w_len_clamped;
                  if (w_len_clamped == '0) begin
                     r_state <= ST_FLUSH;
                  end else begin
                     r_state   <= ST_LOAD;
                     r_nwe     <= 1'b0;
                     r_data_in <= bus.atrByte;
                  end
               end
            end

            // The index advances on leaving LOAD rather than WAIT_TX so that
            // atrByte already reflects the next byte when WAIT_TX registers it
            // into uartDataIn. The last byte leaves the index at length-1.
            ST_LOAD: begin
               r_state <= ST_SETTLE;
               if (5'(r_index) == r_len - 5'd1) begin
                  r_last <= 1'b1;
               end else begin
                  r_index <= r_index + IW'(1);
               end
            end

            ST_SETTLE: begin
               r_state <= ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
               if (!bus.uartStatus[TX_PENDING]) begin
                  if (r_last) begin
                     r_state <= ST_FLUSH;
                  end else begin
                     r_state   <= ST_LOAD;
                     r_nwe     <= 1'b0;
                     r_data_in <= bus.atrByte;
                  end
               end
            end

            ST_FLUSH: begin
               if (w_tx_idle) begin
                  r_atr_done <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_RX_IDLE;
               end
            end

            ST_RX_IDLE: begin
               if (bus.uartStatus[BUFFER_FULL]) begin
                  r_ncs_data <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_READ;
               end
            end

            ST_READ: begin
               r_rx_data  <= bus.uartDataOut;
               r_rx_valid <= 1'b1;
               r_state    <= ST_RX_CLEAR;
            end

            ST_RX_CLEAR: begin
               // Hold here until the UART drops bufferFull so one byte is
               // never read twice.
               if (!bus.uartStatus[BUFFER_FULL]) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_RX_IDLE;
               end
            end

            default: begin
               r_state <= ST_DELAY;
            end
         endcase
      end
   end

   assign bus.atrIndex         = r_index;
   assign bus.uartDataIn       = r_data_in;
   assign bus.uartNWeDataIn    = r_nwe;
   assign bus.uartNCsDataOut   = r_ncs_data;
   assign bus.uartNCsStatusOut = r_ncs_status;
   assign bus.rxData           = r_rx_data;
   assign bus.rxValid          = r_rx_valid;
   assign bus.rxError          = r_rx_error;
   assign bus.atrDone          = r_atr_done;
   assign bus.busy             = r_busy;

endmodule

// File: tb/tb_card_atr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_card_atr_sequencer
// Directed bench for card_atr_sequencer with a small behavioural UART:
// a write keeps txPending high for 10 cycles then txRun/isTx for 4 more;
// a read strobe optionally clears bufferFull.
// Cycle n = the cycle after the n-th rising edge following reset release.
// -----------------------------------------------------------------------------
module tb_card_atr_sequencer;

   localparam int ATR_MAX = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   card_atr_sequencer_if #(.ATR_MAX(ATR_MAX)) bus ();

   card_atr_sequencer #(.ATR_DELAY(400), .ATR_MAX(ATR_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cycle_cnt = 0;
   int rel_base  = 0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   function automatic int rel();
      return cycle_cnt - rel_base;
   endfunction

   // ---------------- stimulus-side variables (written by the main block)
   logic [7:0] atr_rom [ATR_MAX];
   logic [7:0] rx_byte    = 8'h00;
   logic       rx_req     = 1'b0;
   logic       auto_clear = 1'b1;
   logic       frame_err  = 1'b0;

   // ---------------- UART model state (written by the model only)
   int         tx_pend  = 0;
   int         tx_run   = 0;
   logic       rx_taken = 1'b0;
   int         n_reads  = 0;
   int         wr_cycle [$];
   int         wr_idx   [$];
   logic [7:0] wr_byte  [$];
   logic       tx_busy;

   assign bus.atrByte     = atr_rom[bus.atrIndex];
   assign bus.uartDataOut = rx_byte;
   assign tx_busy         = (tx_pend > 0) || (tx_run > 0);
   assign bus.uartStatus  = {tx_busy, (tx_pend > 0), 2'b00, tx_busy, 1'b0,
                             frame_err, (rx_req && !rx_taken)};

   always @(negedge clk) begin
      if (reset) begin
         tx_pend  = 0;
         tx_run   = 0;
         rx_taken = 1'b0;
         n_reads  = 0;
         wr_cycle.delete();
         wr_idx.delete();
         wr_byte.delete();
      end else begin
         if (!bus.uartNWeDataIn) begin
            wr_cycle.push_back(rel());
            wr_idx.push_back(int'(bus.atrIndex));
            wr_byte.push_back(bus.uartDataIn);
            tx_pend = 10;
            tx_run  = 4;
         end else if (tx_pend > 0) begin
            tx_pend = tx_pend - 1;
         end else if (tx_run > 0) begin
            tx_run = tx_run - 1;
         end
         if (!bus.uartNCsDataOut) begin
            n_reads = n_reads + 1;
            if (auto_clear) rx_taken = 1'b1;
         end else if (!rx_req) begin
            rx_taken = 1'b0;
         end
      end
   end

   // ---------------- helpers
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (rel() < n) tick();
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget && at < 0; k++) begin
         tick();
         if (bus.atrDone) at = rel();
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_nwe"},     bus.uartNWeDataIn,    1'b1);
      check({tag, "_ncsd"},    bus.uartNCsDataOut,   1'b1);
      check({tag, "_ncss"},    bus.uartNCsStatusOut, 1'b1);
      check({tag, "_idx"},     bus.atrIndex,         '0);
      check({tag, "_din"},     bus.uartDataIn,       8'h00);
      check({tag, "_rxdata"},  bus.rxData,           8'h00);
      check({tag, "_rxvalid"}, bus.rxValid,          1'b0);
      check({tag, "_rxerr"},   bus.rxError,          1'b0);
      check({tag, "_done"},    bus.atrDone,          1'b0);
      check({tag, "_busy"},    bus.busy,             1'b1);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      repeat (3) tick();
      check_reset_state(tag);
      reset    = 1'b0;
      rel_base = cycle_cnt;
   endtask

   // ---------------- directed sequence
   initial begin : main
      int at;

      for (int i = 0; i < ATR_MAX; i++) atr_rom[i] = 8'hEE;
      atr_rom[0] = 8'h3B;
      atr_rom[1] = 8'h00;
      bus.atrLen = 5'd2;

      // Reset timing: two-byte ATR {3B,00}
      do_reset("rst1");
      wait_until(400);
      check("t1_nwe_c400", bus.uartNWeDataIn, 1'b1);
      check("t1_ncss_run", bus.uartNCsStatusOut, 1'b0);
      wait_until(401);
      check("t1_nwe_c401", bus.uartNWeDataIn, 1'b0);
      check("t1_din_c401", bus.uartDataIn, 8'h3B);
      check("t1_idx_c401", bus.atrIndex, 0);
      tick();
      check("t1_nwe_c402", bus.uartNWeDataIn, 1'b1);
      wait_done(200, at);
      check("t1_done_cycle", at, 427);
      check("t1_wr_count", wr_cycle.size(), 2);
      if (wr_cycle.size() >= 2) begin
         check("t1_wr1_cycle", wr_cycle[1], 412);
         check("t1_wr1_byte", wr_byte[1], 8'h00);
         check("t1_wr1_idx", wr_idx[1], 1);
      end
      check("t1_busy_rx", bus.busy, 1'b0);

      // Receive path, auto-clearing bufferFull
      rx_byte = 8'hA5; auto_clear = 1'b1; rx_req = 1'b1;
      tick();
      check("rx1_ncsd_low", bus.uartNCsDataOut, 1'b0);
      check("rx1_valid_early", bus.rxValid, 1'b0);
      tick();
      check("rx1_valid", bus.rxValid, 1'b1);
      check("rx1_data", bus.rxData, 8'hA5);
      check("rx1_ncsd_high", bus.uartNCsDataOut, 1'b1);
      tick();
      check("rx1_valid_pulse", bus.rxValid, 1'b0);
      check("rx1_reads", n_reads, 1);
      rx_req = 1'b0;
      repeat (2) tick();

      // Receive path, bufferFull held high after the read
      rx_byte = 8'h5A; auto_clear = 1'b0; rx_req = 1'b1;
      repeat (2) tick();
      check("rx2_valid", bus.rxValid, 1'b1);
      check("rx2_data", bus.rxData, 8'h5A);
      repeat (8) tick();
      check("rx2_single_read", n_reads, 2);
      check("rx2_busy_hold", bus.busy, 1'b1);
      rx_req = 1'b0;
      tick();
      check("rx2_busy_release", bus.busy, 1'b0);
      check("rx2_reads_final", n_reads, 2);
      auto_clear = 1'b1;

      // Error flag: one-cycle frame error pulse is sticky
      check("err_clear_before", bus.rxError, 1'b0);
      frame_err = 1'b1;
      tick();
      frame_err = 1'b0;
      check("err_set", bus.rxError, 1'b1);
      repeat (5) tick();
      check("err_sticky", bus.rxError, 1'b1);

      // Length clamp: atrLen=20 -> 16 writes; bufferFull during TX ignored
      for (int i = 0; i < ATR_MAX; i++) atr_rom[i] = 8'h10 + 8'(i);
      bus.atrLen = 5'd20;
      do_reset("rst_clamp");
      wait_until(100);
      rx_byte = 8'hC3; rx_req = 1'b1;
      wait_done(1000, at);
      check("clamp_done_cycle", at, 581);
      check("clamp_no_read_in_tx", n_reads, 0);
      check("clamp_wr_count", wr_cycle.size(), 16);
      for (int i = 0; i < wr_cycle.size(); i++) begin
         check($sformatf("clamp_idx%0d", i), wr_idx[i], i);
         check($sformatf("clamp_byte%0d", i), wr_byte[i], 8'h10 + 8'(i));
         if (i > 0) check($sformatf("clamp_gap%0d", i), wr_cycle[i] - wr_cycle[i-1], 11);
      end
      repeat (3) tick();
      check("clamp_late_read", n_reads, 1);
      check("clamp_late_data", bus.rxData, 8'hC3);
      rx_req = 1'b0;

      // Mid-ATR reset while byte 1 is being written
      atr_rom[0] = 8'h3B;
      atr_rom[1] = 8'h00;
      bus.atrLen = 5'd2;
      do_reset("rst_mid");
      wait_until(412);
      check("mid_wr1_nwe", bus.uartNWeDataIn, 1'b0);
      check("mid_wr1_idx", bus.atrIndex, 1);
      reset = 1'b1;
      #1;
      check("mid_async_nwe", bus.uartNWeDataIn, 1'b1);
      check("mid_async_ncsd", bus.uartNCsDataOut, 1'b1);
      check("mid_async_idx", bus.atrIndex, 0);
      repeat (2) tick();
      reset    = 1'b0;
      rel_base = cycle_cnt;
      wait_until(400);
      check("mid_restart_c400", bus.uartNWeDataIn, 1'b1);
      wait_until(401);
      check("mid_restart_nwe", bus.uartNWeDataIn, 1'b0);
      check("mid_restart_idx", bus.atrIndex, 0);
      check("mid_restart_byte", bus.uartDataIn, 8'h3B);

      // Empty ATR: no write strobe, atrDone right after FLUSH
      bus.atrLen = 5'd0;
      do_reset("rst_empty");
      wait_until(401);
      check("empty_done_c401", bus.atrDone, 1'b0);
      check("empty_busy_c401", bus.busy, 1'b1);
      tick();
      check("empty_done_c402", bus.atrDone, 1'b1);
      check("empty_busy_c402", bus.busy, 1'b0);
      wait_until(420);
      check("empty_no_writes", wr_cycle.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
